bp_mem_arbiter: RTL and testbench

Two-port front end for the test memory: merges command streams from two coherence engines into the single command channel of `bp_mem`, then routes each memory response back to the port that issued it. Ports are served round-robin, and a small in-order tag FIFO records which port issued each outstanding command. The block sits directly upstream of `bp_mem` in ME test benches with more than one CCE.

---
 rtl/bp_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_bp_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_mem_arbiter.sv
// Two-port round-robin command merger in front of bp_mem, with an in-order
// tag FIFO that steers each response back to the port that issued it.
module bp_mem_arbiter #(
    parameter int unsigned cce_mem_msg_width_lp = 64,
    parameter int unsigned pending_depth_p      = 4,
    localparam int unsigned cnt_width_lp        = $clog2(pending_depth_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,

    input  logic [2*cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic [1:0]                        mem_cmd_v_i,
    output logic [1:0]                        mem_cmd_yumi_o,

    output logic [2*cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic [1:0]                        mem_resp_v_o,
    input  logic [1:0]                        mem_resp_ready_i,

    output logic [cce_mem_msg_width_lp-1:0]   mem_cmd_o,
    output logic                              mem_cmd_v_o,
    input  logic                              mem_cmd_yumi_i,

    input  logic [cce_mem_msg_width_lp-1:0]   mem_resp_i,
    input  logic                              mem_resp_v_i,
    output logic                              mem_resp_ready_o,

    output logic [cnt_width_lp-1:0]           pending_o,
    output logic                              err_o
);

    localparam int unsigned ptr_width_lp = (pending_depth_p > 1) ? $clog2(pending_depth_p) : 1;
    localparam int unsigned w_lp         = cce_mem_msg_width_lp;

    logic                       prio_q, prio_d;
    logic                       lock_q, lock_d;
    logic                       lock_port_q, lock_port_d;
    logic                       err_q, err_d;
    logic [ptr_width_lp-1:0]    rptr_q, rptr_d;
    logic [ptr_width_lp-1:0]    wptr_q, wptr_d;
    logic [cnt_width_lp-1:0]    count_q, count_d;
    logic [pending_depth_p-1:0] tags_q, tags_d;

    logic full, empty, grant, head, push, pop;

    // Grant selection, downstream command handshake and response steering.
    always_comb begin
        full  = (count_q == cnt_width_lp'(pending_depth_p));
        empty = (count_q == '0);

        if (lock_q) begin
            grant = lock_port_q;
        end else if (&mem_cmd_v_i) begin
            grant = prio_q;
        end else begin
            grant = mem_cmd_v_i[1];
        end

        // Gated by reset so every handshake output is quiet while reset is held.
        mem_cmd_v_o = reset_n_i & ~full & (lock_q ? mem_cmd_v_i[grant] : (|mem_cmd_v_i));
        mem_cmd_o   = grant ? mem_cmd_i[2*w_lp-1:w_lp] : mem_cmd_i[w_lp-1:0];
        push        = mem_cmd_v_o & mem_cmd_yumi_i;

        mem_cmd_yumi_o        = '0;
        mem_cmd_yumi_o[grant] = push;

        head = tags_q[rptr_q];

        mem_resp_ready_o     = reset_n_i & ~empty & mem_resp_ready_i[head];
        mem_resp_v_o         = '0;
        mem_resp_v_o[head]   = reset_n_i & ~empty & mem_resp_v_i;
        pop                  = mem_resp_v_i & mem_resp_ready_o;
    end

    assign mem_resp_o = {2{mem_resp_i}};
    assign pending_o  = count_q;
    assign err_o      = err_q;

    // Next-state: priority, lock, tag FIFO and sticky error.
    always_comb begin
        prio_d      = prio_q;
        lock_d      = lock_q;
        lock_port_d = lock_port_q;
        err_d       = err_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        count_d     = count_q;
        tags_d      = tags_q;

        if (push) begin
            prio_d         = ~grant;
            lock_d         = 1'b0;
            tags_d[wptr_q] = grant;
            wptr_d         = (wptr_q == ptr_width_lp'(pending_depth_p - 1))
                             ? '0 : wptr_q + ptr_width_lp'(1);
        end else if (mem_cmd_v_o) begin
            lock_d      = 1'b1;
            lock_port_d = grant;
        end

        if (pop) begin
            rptr_d = (rptr_q == ptr_width_lp'(pending_depth_p - 1))
                     ? '0 : rptr_q + ptr_width_lp'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + cnt_width_lp'(1);
            2'b01:   count_d = count_q - cnt_width_lp'(1);
            default: count_d = count_q;
        endcase

        // A response with nothing outstanding is a downstream protocol violation.
        err_d = err_q | (mem_resp_v_i & empty);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prio_q      <= 1'b0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
            err_q       <= 1'b0;
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            tags_q      <= '0;
        end else begin
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_port_q <= lock_port_d;
            err_q       <= err_d;
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            tags_q      <= tags_d;
        end
    end

endmodule

// File: tb/tb_bp_mem_arbiter.sv
// Self-checking bench for bp_mem_arbiter: directed vector table, hand-written
// lock/error/reset sequences, then random traffic against a queue-based model.
module tb_bp_mem_arbiter;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           reset_n;
    logic [2*W-1:0] cmd_i;
    logic [1:0]     cmd_v_i;
    logic [1:0]     cmd_yumi_o;
    logic [2*W-1:0] resp_o;
    logic [1:0]     resp_v_o;
    logic [1:0]     resp_ready_i;
    logic [W-1:0]   cmd_o;
    logic           cmd_v_o;
    logic           cmd_yumi_i;
    logic [W-1:0]   resp_i;
    logic           resp_v_i;
    logic           resp_ready_o;
    logic [CW-1:0]  pending;
    logic           err;

    always #5 clk = ~clk;

    bp_mem_arbiter #(.cce_mem_msg_width_lp(W), .pending_depth_p(DEPTH)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .mem_cmd_i(cmd_i), .mem_cmd_v_i(cmd_v_i), .mem_cmd_yumi_o(cmd_yumi_o),
        .mem_resp_o(resp_o), .mem_resp_v_o(resp_v_o), .mem_resp_ready_i(resp_ready_i),
        .mem_cmd_o(cmd_o), .mem_cmd_v_o(cmd_v_o), .mem_cmd_yumi_i(cmd_yumi_i),
        .mem_resp_i(resp_i), .mem_resp_v_i(resp_v_i), .mem_resp_ready_o(resp_ready_o),
        .pending_o(pending), .err_o(err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic ecv, input logic [W-1:0] ecmd,
                              input logic [1:0] eyum, input logic [1:0] erv, input logic err_rdy,
                              input logic [CW-1:0] epend, input logic eerr);
        chk({tag, ".cmd_v"}, 32'(cmd_v_o), 32'(ecv));
        if (ecv) chk({tag, ".cmd"}, 32'(cmd_o), 32'(ecmd));
        chk({tag, ".yumi"}, 32'(cmd_yumi_o), 32'(eyum));
        chk({tag, ".resp_v"}, 32'(resp_v_o), 32'(erv));
        chk({tag, ".resp_ready"}, 32'(resp_ready_o), 32'(err_rdy));
        chk({tag, ".pending"}, 32'(pending), 32'(epend));
        chk({tag, ".err"}, 32'(err), 32'(eerr));
    endtask

    task automatic drive(input logic [1:0] v, input logic yi, input logic rv, input logic [1:0] rr);
        cmd_v_i      = v;
        cmd_yumi_i   = yi;
        resp_v_i     = rv;
        resp_ready_i = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        cmd_i  = '0;
        resp_i = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Behavioural model: a queue of issuing-port ids plus priority, lock and error.
    int unsigned tagq[$];
    int unsigned m_prio;
    int          m_lock;
    bit          m_err;
    int unsigned m_g;
    logic        e_cv;
    logic [1:0]  e_yum, e_rv;
    logic        e_rr;

    task automatic m_init();
        tagq.delete();
        m_prio = 0;
        m_lock = -1;
        m_err  = 1'b0;
    endtask

    task automatic m_eval(input logic [1:0] v, input logic yi, input logic rv, input logic [1:0] rr);
        bit          full;
        bit          empty;
        int unsigned h;
        full  = (tagq.size() == DEPTH);
        empty = (tagq.size() == 0);
        if (m_lock >= 0)     m_g = int'(m_lock);
        else if (v == 2'b11) m_g = m_prio;
        else                 m_g = v[1] ? 1 : 0;
        if (m_lock >= 0) e_cv = v[m_g] && !full;
        else             e_cv = (v != 2'b00) && !full;
        e_yum = (e_cv && yi) ? 2'(1 << m_g) : 2'b00;
        h     = empty ? 0 : tagq[0];
        e_rv  = (rv && !empty) ? 2'(1 << h) : 2'b00;
        e_rr  = !empty && rr[h];
    endtask

    task automatic m_step(input logic yi, input logic rv);
        bit push;
        bit pop;
        push = e_cv && yi;
        pop  = rv && e_rr;
        if (rv && tagq.size() == 0) m_err = 1'b1;
        if (pop) void'(tagq.pop_front());
        if (push) begin
            tagq.push_back(m_g);
            m_prio = 1 - m_g;
            m_lock = -1;
        end else if (e_cv) begin
            m_lock = int'(m_g);
        end
    endtask

    typedef struct {
        logic [1:0]    v;
        logic          yi;
        logic          rv;
        logic [1:0]    rr;
        logic          cv;
        logic          g;
        logic [1:0]    yum;
        logic [1:0]    rvo;
        logic          rro;
        logic [CW-1:0] pend;
        logic          err;
    } vec_t;

    vec_t tbl[16];

    localparam logic [W-1:0] D0 = 16'hA0A0;
    localparam logic [W-1:0] D1 = 16'hB1B1;

    logic [1:0]   pv;
    logic [W-1:0] pd[2];

    initial begin
        tbl[0]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 3'd1, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1, 3'd1, 1'b0};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 3'd1, 1'b0};
        tbl[4]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 3'd2, 1'b0};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 3'd3, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 3'd4, 1'b0};
        tbl[7]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 3'd4, 1'b0};
        tbl[8]  = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 3'd3, 1'b0};
        tbl[9]  = '{2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 3'd4, 1'b0};
        tbl[10] = '{2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 3'd4, 1'b0};
        tbl[11] = '{2'b10, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 3'd3, 1'b0};
        tbl[12] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 3'd3, 1'b0};
        tbl[13] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 3'd2, 1'b0};
        tbl[14] = '{2'b00, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 3'd1, 1'b0};
        tbl[15] = '{2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0};

        // Directed table: alternation, full FIFO, same-cycle pop, head-port ready.
        do_reset();
        cmd_i = {D1, D0};
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].yi, tbl[i].rv, tbl[i].rr);
            #2;
            check_outs($sformatf("tbl%0d", i), tbl[i].cv, tbl[i].g ? D1 : D0,
                       tbl[i].yum, tbl[i].rvo, tbl[i].rro, tbl[i].pend, tbl[i].err);
            tick();
        end

        // Lock: port 0 stalled by bp_mem keeps the grant although port 1 is favoured.
        do_reset();
        cmd_i = {16'h3333, 16'h1111};
        drive(2'b01, 1'b1, 1'b0, 2'b00); #2;
        check_outs("lock0", 1'b1, 16'h1111, 2'b01, 2'b00, 1'b0, 3'd0, 1'b0); tick();
        cmd_i = {16'h3333, 16'h2222};
        drive(2'b01, 1'b0, 1'b0, 2'b00); #2;
        check_outs("lock1", 1'b1, 16'h2222, 2'b00, 2'b00, 1'b0, 3'd1, 1'b0); tick();
        drive(2'b11, 1'b0, 1'b0, 2'b00); #2;
        check_outs("lock2", 1'b1, 16'h2222, 2'b00, 2'b00, 1'b0, 3'd1, 1'b0); tick();
        drive(2'b11, 1'b0, 1'b0, 2'b00); #2;
        check_outs("lock3", 1'b1, 16'h2222, 2'b00, 2'b00, 1'b0, 3'd1, 1'b0); tick();
        drive(2'b11, 1'b1, 1'b0, 2'b00); #2;
        check_outs("lock4", 1'b1, 16'h2222, 2'b01, 2'b00, 1'b0, 3'd1, 1'b0); tick();
        drive(2'b10, 1'b1, 1'b0, 2'b00); #2;
        check_outs("lock5", 1'b1, 16'h3333, 2'b10, 2'b00, 1'b0, 3'd2, 1'b0); tick();

        // Response while empty sets sticky error; async reset silences outputs at once.
        do_reset();
        drive(2'b00, 1'b0, 1'b1, 2'b11); #2;
        check_outs("err0", 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0); tick();
        drive(2'b00, 1'b0, 1'b0, 2'b11); #2;
        check_outs("err1", 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1); tick();
        cmd_i = {D1, D0};
        drive(2'b11, 1'b1, 1'b0, 2'b11); #2;
        check_outs("err2", 1'b1, D0, 2'b01, 2'b00, 1'b0, 3'd0, 1'b1); tick();
        drive(2'b11, 1'b1, 1'b1, 2'b11); #1;
        reset_n = 1'b0; #1;
        check_outs("rst", 1'b0, '0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
        tick();

        // Random traffic against the model; producers hold until consumed.
        do_reset();
        m_init();
        pv = 2'b00;
        pd[0] = '0;
        pd[1] = '0;
        for (int c = 0; c < 3000; c++) begin
            logic       yi;
            logic       rv;
            logic [1:0] rr;
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && ($urandom_range(0, 1) == 1)) begin
                    pv[k] = 1'b1;
                    pd[k] = W'($urandom);
                end
            end
            cmd_i  = {pd[1], pd[0]};
            resp_i = W'($urandom);
            if (tagq.size() != 0) rv = ($urandom_range(0, 3) != 0);
            else                  rv = ($urandom_range(0, 15) == 0);
            rr = 2'($urandom_range(0, 3));
            m_eval(pv, 1'b0, rv, rr);
            yi = e_cv && ($urandom_range(0, 2) != 0);
            m_eval(pv, yi, rv, rr);
            drive(pv, yi, rv, rr);
            #2;
            check_outs("rnd", e_cv, m_g ? pd[1] : pd[0], e_yum, e_rv, e_rr,
                       CW'(tagq.size()), m_err);
            chk("rnd.resp_data", resp_o, {resp_i, resp_i});
            m_step(yi, rv);
            for (int k = 0; k < 2; k++) if (e_yum[k]) pv[k] = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
